// File: rtl/rotor_2_reverse_if.sv
// Character stream bundle for the rotor II return stage: input handshake from
// the reflector side, output handshake towards the rotor I return stage.
interface rotor_2_reverse_if;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned OUT_W  = 16;

    logic              in_valid;
    logic              in_ready;
    logic [CHAR_W-1:0] rotor_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  rotor_out;

    modport slave (
        input  in_valid,
        input  rotor_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output rotor_out
    );

    modport master (
        output in_valid,
        output rotor_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  rotor_out
    );
endinterface

// File: rtl/rotor_2_reverse.sv
// Enigma rotor II return path: inverse wiring at the current position and ring
// setting, own position register, two-stage valid/ready pipeline.
module rotor_2_reverse #(
    parameter int unsigned INIT_POS = 0,
    parameter int unsigned RING     = 0,
    parameter int unsigned NOTCH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [4:0]           load_pos,
    input  logic                 step,
    output logic                 carry_out,
    rotor_2_reverse_if.slave     bus
);
    localparam int unsigned POS_W  = 5;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned SUM_W  = 7;
    localparam int unsigned OUT_W  = 16;

    // Folds a value in 0..77 back into 0..25.
    function automatic logic [POS_W-1:0] mod26(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] r;
        r = v;
        if (r >= SUM_W'(52))      r = r - SUM_W'(52);
        else if (r >= SUM_W'(26)) r = r - SUM_W'(26);
        return POS_W'(r);
    endfunction

    // Inverse rotor II wiring: AJPCZWRLFBDKOTYUQGENHXMIVS.
    function automatic logic [POS_W-1:0] inv_lut(input logic [POS_W-1:0] i);
        logic [POS_W-1:0] r;
        r = '0;
        case (i)
            5'd0:  r = 5'd0;   5'd1:  r = 5'd9;   5'd2:  r = 5'd15;  5'd3:  r = 5'd2;
            5'd4:  r = 5'd25;  5'd5:  r = 5'd22;  5'd6:  r = 5'd17;  5'd7:  r = 5'd11;
            5'd8:  r = 5'd5;   5'd9:  r = 5'd1;   5'd10: r = 5'd3;   5'd11: r = 5'd10;
            5'd12: r = 5'd14;  5'd13: r = 5'd19;  5'd14: r = 5'd24;  5'd15: r = 5'd20;
            5'd16: r = 5'd16;  5'd17: r = 5'd6;   5'd18: r = 5'd4;   5'd19: r = 5'd13;
            5'd20: r = 5'd7;   5'd21: r = 5'd23;  5'd22: r = 5'd12;  5'd23: r = 5'd8;
            5'd24: r = 5'd21;  5'd25: r = 5'd18;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [POS_W-1:0]  pos;
    logic              s1_valid;
    logic              s1_letter;
    logic [CHAR_W-1:0] s1_char;
    logic [POS_W-1:0]  s1_pos;
    logic [POS_W-1:0]  s1_idx;

    logic              s2_adv;
    logic              letter;
    logic [POS_W-1:0]  idx;
    logic [POS_W-1:0]  y;
    logic [CHAR_W-1:0] out_byte;

    // Pipeline control and per-stage arithmetic.
    always_comb begin
        s2_adv       = !bus.out_valid || bus.out_ready;
        bus.in_ready = !s1_valid || s2_adv;
        letter       = (bus.rotor_in >= CHAR_W'(65)) && (bus.rotor_in <= CHAR_W'(90));
        idx          = '0;
        if (letter)
            idx = mod26(SUM_W'(bus.rotor_in - CHAR_W'(65)) + SUM_W'(pos) + SUM_W'(26 - RING));
        y        = mod26(SUM_W'(inv_lut(s1_idx)) + SUM_W'(26) + SUM_W'(RING) - SUM_W'(s1_pos));
        out_byte = s1_letter ? (CHAR_W'(y) + CHAR_W'(65)) : s1_char;
    end

    // Position register; a load command (valid or not) suppresses the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos       <= POS_W'(INIT_POS);
            carry_out <= 1'b0;
        end else begin
            carry_out <= !load && step && (pos == POS_W'(NOTCH));
            if (load) begin
                if (load_pos <= POS_W'(25)) pos <= load_pos;
            end else if (step) begin
                pos <= (pos == POS_W'(25)) ? '0 : pos + POS_W'(1);
            end
        end
    end

    // Stage 1: capture character, pre-update position and table index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_letter <= 1'b0;
            s1_char   <= '0;
            s1_pos    <= '0;
            s1_idx    <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_letter <= letter;
                s1_char   <= bus.rotor_in;
                s1_pos    <= pos;
                s1_idx    <= idx;
            end
        end
    end

    // Stage 2: registered output, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.rotor_out <= '0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid)
                bus.rotor_out <= OUT_W'({CHAR_W'(s1_pos) + CHAR_W'(65), out_byte});
        end
    end
endmodule

// File: tb/tb_rotor_2_reverse.sv
// Scoreboard bench for rotor_2_reverse: directed sequences plus randomized
// traffic checked against a plain-arithmetic Enigma rotor II model.
module tb_rotor_2_reverse;
    localparam int unsigned INIT_POS = 0;
    localparam int unsigned RING     = 0;
    localparam int unsigned NOTCH    = 4;

    typedef struct {
        logic [15:0] d;
        int          c;
        bit          ex;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] load_pos;
    logic       step;
    logic       carry_out;

    rotor_2_reverse_if bus ();

    rotor_2_reverse #(.INIT_POS(INIT_POS), .RING(RING), .NOTCH(NOTCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_pos (load_pos),
        .step     (step),
        .carry_out(carry_out),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];
    int  mpos;
    bit  exp_carry;
    bit  lat_chk;
    bit  last_acc;
    int  n_acc;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: locate the forward-wiring contact that lands on the shifted letter.
    function automatic logic [15:0] model(input logic [7:0] c, input int p);
        string fwd;
        int    x, k, j, y;
        fwd = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
        if (c < 8'd65 || c > 8'd90) return {8'(65 + p), c};
        x = int'(c) - 65;
        k = (((x + p - int'(RING)) % 26) + 26) % 26;
        j = 0;
        for (int i = 0; i < 26; i++)
            if (fwd[i] == 8'(65 + k)) j = i;
        y = (((j - p + int'(RING)) % 26) + 26) % 26;
        return {8'(65 + p), 8'(65 + y)};
    endfunction

    // One clock: check carry, log an accept, advance the position model.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        chk("carry_out", {15'd0, carry_out}, {15'd0, exp_carry});
        last_acc = bus.in_valid && bus.in_ready;
        if (last_acc) begin
            e.d  = model(bus.rotor_in, mpos);
            e.c  = cyc;
            e.ex = lat_chk;
            sb.push_back(e);
            n_acc++;
        end
        exp_carry = !load && step && (mpos == int'(NOTCH));
        if (load) begin
            if (load_pos <= 5'd25) mpos = int'(load_pos);
        end else if (step) begin
            mpos = (mpos + 1) % 26;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch);
        int n;
        bus.in_valid = 1'b1;
        bus.rotor_in = ch;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("accept_timeout", 16'd0, 16'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic cmd(input logic l, input logic [4:0] lp, input logic s);
        load = l; load_pos = lp; step = s;
        tick();
        load = 1'b0; step = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", 16'(sb.size()), 16'd0);
    endtask

    // Monitor: pop on transfer, verify hold value during stall.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", bus.rotor_out, 16'hxxxx);
            end else if (bus.out_ready) begin
                e = sb.pop_front();
                chk("rotor_out", bus.rotor_out, e.d);
                if (e.ex) chk("latency", 16'(cyc - e.c), 16'd2);
            end else begin
                chk("stall_hold", bus.rotor_out, sb[0].d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1[5];
        logic [7:0] t5[4];
        int         idx5;
        logic       rnd_load;
        t1 = '{8'd65, 8'd66, 8'd67, 8'd83, 8'd90};
        t5 = '{8'd77, 8'd81, 8'd88, 8'd32};

        rst = 1'b1; load = 1'b0; load_pos = '0; step = 1'b0;
        bus.in_valid = 1'b0; bus.rotor_in = '0; bus.out_ready = 1'b1;
        mpos = int'(INIT_POS); exp_carry = 1'b0; lat_chk = 1'b1; n_acc = 0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("reset_rotor_out", bus.rotor_out, 16'h0000);
        chk("reset_carry", {15'd0, carry_out}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back letters at position A.
        foreach (t1[i]) send(t1[i]);
        drain();

        // Load position B.
        cmd(1'b1, 5'd1, 1'b0);
        send(8'd65);
        drain();

        // Turnover at the notch, wrap without turnover.
        cmd(1'b1, 5'd4, 1'b0);
        cmd(1'b0, 5'd0, 1'b1);
        tick();
        send(8'd65);
        cmd(1'b1, 5'd25, 1'b0);
        cmd(1'b0, 5'd0, 1'b1);
        tick();
        send(8'd65);
        drain();

        // Accept and step on the same edge uses the old position.
        step = 1'b1;
        send(8'd65);
        step = 1'b0;
        send(8'd65);
        cmd(1'b1, 5'd3, 1'b1);
        tick();
        send(8'd66);
        drain();

        // Backpressure: only two characters fit while stalled.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        n_acc = 0;
        idx5 = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (idx5 < 4);
            bus.rotor_in = t5[idx5 % 4];
            tick();
            if (last_acc) idx5++;
        end
        chk("stall_accepts", 16'(n_acc), 16'd2);
        chk("stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && idx5 < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.rotor_in = t5[idx5];
            tick();
            if (last_acc) idx5++;
        end
        chk("stall_all_sent", 16'(idx5), 16'd4);
        drain();
        lat_chk = 1'b1;

        // Non-letter passthrough, then reset with a character in flight.
        send(8'h20);
        drain();
        cmd(1'b1, 5'd9, 1'b0);
        send(8'd72);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("midreset_rotor_out", bus.rotor_out, 16'h0000);
        sb.delete();
        mpos = int'(INIT_POS);
        exp_carry = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'd65);
        drain();

        // Out-of-range load is ignored.
        cmd(1'b1, 5'd7, 1'b0);
        cmd(1'b1, 5'd30, 1'b0);
        send(8'd65);
        send(8'd90);
        drain();

        // Randomized traffic with random loads, steps and backpressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.rotor_in  = (($urandom % 8) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(65, 90));
            bus.out_ready = ($urandom % 4) != 0;
            rnd_load      = ($urandom % 16) == 0;
            load          = rnd_load;
            load_pos      = 5'($urandom_range(0, 31));
            step          = (($urandom % 6) == 0) && !(rnd_load && load_pos > 5'd25);
            tick();
        end
        load = 1'b0;
        step = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
